// File: rtl/column_scheduler.sv
// column_scheduler: frame/column sequencer sitting between an input column
// buffer and the convolution output path. Counts accepted rows/columns,
// requests a zero-padding flush at end of frame, waits for the output side
// to emit every column, drains the pipeline, then pulses batch-complete.
// Optional build macro: COLUMN_SCHED_STATS_EN adds the stall_cycles counter.
module column_scheduler #(
  parameter int BLOCK_SIZE   = 3,
  parameter int INPUT_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               in_tvalid,
  input  logic                               in_tready,
  input  logic                               in_tlast,
  input  logic                               out_tvalid,
  input  logic                               out_tready,
  output logic                               in_enable,
  output logic                               flush_req,
  output logic                               output_buffer_is_done,
  output logic [$clog2(IMAGE_WIDTH+1)-1:0]   col_index,
  output logic [1:0]                         state,
  output logic                               frame_done,
  output logic                               tlast_error
`ifdef COLUMN_SCHED_STATS_EN
  ,
  output logic [31:0]                        stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned RW = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
  localparam int unsigned DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(INPUT_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX    = CW'(IMAGE_WIDTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_LATENCY > 0) ? PIPE_LATENCY - 1 : 0);

  // A window wider than the frame can never produce an output column.
  if (BLOCK_SIZE < 1 || BLOCK_SIZE > IMAGE_WIDTH) begin : g_bad_block
    $error("column_scheduler: BLOCK_SIZE must be in 1..IMAGE_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        cur, state_n;
  logic [RW-1:0] row, row_n;
  logic [RW-1:0] out_row, out_row_n;
  logic [CW-1:0] out_col, out_col_n;
  logic [CW-1:0] col_n, col_inc;
  logic [DW-1:0] drain_cnt, drain_n;
  logic          err_n, done_n;
  logic          accept, emit;

  assign accept  = in_tvalid && in_tready;
  assign emit    = out_tvalid && out_tready;
  assign col_inc = col_index + CW'(1);
  assign state   = cur;

  // Next-state and next-counter decode.
  always_comb begin
    state_n   = cur;
    row_n     = row;
    col_n     = col_index;
    err_n     = tlast_error;
    out_row_n = out_row;
    out_col_n = out_col;
    drain_n   = drain_cnt;
    done_n    = 1'b0;

    if (emit) begin
      if (out_row == ROW_LAST) begin
        out_row_n = '0;
        out_col_n = out_col + CW'(1);
      end else begin
        out_row_n = out_row + RW'(1);
      end
    end

    case (cur)
      IDLE, STREAM: begin
        if (accept) begin
          // tlast closes the column even when it is short, so a partial
          // column still counts towards col_index.
          if (row == ROW_LAST || in_tlast) begin
            row_n = '0;
            col_n = col_inc;
          end else begin
            row_n = row + RW'(1);
          end
          if (in_tlast) begin
            state_n = FLUSH;
            if (row != ROW_LAST) err_n = 1'b1;
          end else if (row == ROW_LAST && col_inc == COL_MAX) begin
            state_n = FLUSH;
            err_n   = 1'b1;
          end else begin
            state_n = STREAM;
          end
        end
      end
      FLUSH: begin
        if (out_col == col_index) begin
          state_n = DRAIN;
          drain_n = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n   = IDLE;
          done_n    = 1'b1;
          row_n     = '0;
          col_n     = '0;
          out_row_n = '0;
          out_col_n = '0;
          drain_n   = '0;
        end else begin
          drain_n = drain_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cur                   <= IDLE;
      row                   <= '0;
      out_row               <= '0;
      out_col               <= '0;
      drain_cnt             <= '0;
      col_index             <= '0;
      tlast_error           <= 1'b0;
      in_enable             <= 1'b1;
      flush_req             <= 1'b0;
      output_buffer_is_done <= 1'b0;
      frame_done            <= 1'b0;
    end else begin
      cur                   <= state_n;
      row                   <= row_n;
      out_row               <= out_row_n;
      out_col               <= out_col_n;
      drain_cnt             <= drain_n;
      col_index             <= col_n;
      tlast_error           <= err_n;
      in_enable             <= (state_n == IDLE) || (state_n == STREAM);
      flush_req             <= (state_n == FLUSH);
      output_buffer_is_done <= done_n;
      frame_done            <= done_n;
    end
  end

`ifdef COLUMN_SCHED_STATS_EN
  // Upstream-stall counter for STREAM, saturating, restarted per frame.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_cycles <= '0;
    end else if (state_n == IDLE && cur != IDLE) begin
      stall_cycles <= '0;
    end else if (cur == STREAM && in_tvalid && !in_tready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_column_scheduler.sv
// Self-checking bench for column_scheduler (H=4, W=3, PL=2): directed
// scenarios plus randomized frames, checked each cycle against a
// beat-count reference model.
module tb_column_scheduler;

  localparam int H  = 4;
  localparam int IW = 3;
  localparam int BS = 3;
  localparam int PL = 2;
  localparam int CW = $clog2(IW + 1);

  logic          aclk = 1'b0;
  logic          areset, in_tvalid, in_tready, in_tlast, out_tvalid, out_tready;
  logic          in_enable, flush_req, obd, frame_done, tlast_error;
  logic [CW-1:0] col_index;
  logic [1:0]    state;
`ifdef COLUMN_SCHED_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   m_stall;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: beats accepted/emitted this frame, phase 0..3.
  int m_phase, m_acc, m_emit, m_col, m_drain;
  bit m_err, m_done;

  always #5 aclk = ~aclk;

  column_scheduler #(
    .BLOCK_SIZE  (BS),
    .INPUT_HEIGHT(H),
    .IMAGE_WIDTH (IW),
    .PIPE_LATENCY(PL)
  ) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .in_tvalid            (in_tvalid),
    .in_tready            (in_tready),
    .in_tlast             (in_tlast),
    .out_tvalid           (out_tvalid),
    .out_tready           (out_tready),
    .in_enable            (in_enable),
    .flush_req            (flush_req),
    .output_buffer_is_done(obd),
    .col_index            (col_index),
    .state                (state),
    .frame_done           (frame_done),
    .tlast_error          (tlast_error)
`ifdef COLUMN_SCHED_STATS_EN
    ,
    .stall_cycles         (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit acc, em;
    int old_phase, ocol_old;
    acc = in_tvalid && in_tready;
    em  = out_tvalid && out_tready;
    old_phase = m_phase;
    m_done = 1'b0;
    if (areset) begin
      m_phase = 0; m_acc = 0; m_emit = 0; m_col = 0; m_drain = 0; m_err = 1'b0;
    end else begin
      ocol_old = m_emit / H;
      if (em) m_emit++;
      case (m_phase)
        0, 1: if (acc) begin
          m_acc++;
          if (in_tlast) begin
            if (m_acc % H != 0) m_err = 1'b1;
            m_col = (m_acc + H - 1) / H;
            m_phase = 2;
          end else begin
            m_col = m_acc / H;
            if (m_col == IW) begin
              m_err = 1'b1;
              m_phase = 2;
            end else begin
              m_phase = 1;
            end
          end
        end
        2: if (ocol_old == m_col) begin
          m_phase = 3;
          m_drain = 0;
        end
        default: if (m_drain == PL - 1) begin
          m_phase = 0; m_done = 1'b1; m_acc = 0; m_emit = 0; m_col = 0; m_drain = 0;
        end else begin
          m_drain++;
        end
      endcase
    end
`ifdef COLUMN_SCHED_STATS_EN
    if (areset || (m_phase == 0 && old_phase != 0)) m_stall = '0;
    else if (old_phase == 1 && in_tvalid && !in_tready && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
  endtask

  task automatic compare_all();
    check("state", 32'(state), m_phase);
    check("col_index", 32'(col_index), m_col);
    check("tlast_error", 32'(tlast_error), 32'(m_err));
    check("in_enable", 32'(in_enable), 32'(m_phase <= 1));
    check("flush_req", 32'(flush_req), 32'(m_phase == 2));
    check("done", 32'(obd), 32'(m_done));
    check("frame_done", 32'(frame_done), 32'(m_done));
`ifdef COLUMN_SCHED_STATS_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic r, input logic l, input logic ov, input logic orr);
    in_tvalid = v; in_tready = r; in_tlast = l; out_tvalid = ov; out_tready = orr;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Emit exactly what is still owed, then wait for the done pulse.
  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      drive(0, 0, 0, (m_phase == 2) && (m_emit / H < m_col), 1);
      tick();
      if (obd) seen = 1'b1;
    end
    check(tag, 32'(seen), 1);
  endtask

  initial begin
    int drain_seen, done_seen;
    bit seen;
`ifdef COLUMN_SCHED_STATS_EN
    m_stall = '0;
`endif
    areset = 1'b1;
    drive(0, 0, 0, 0, 0);
    m_phase = 0; m_acc = 0; m_emit = 0; m_col = 0; m_drain = 0; m_err = 0; m_done = 0;
    do_reset();
    check("rst_state", 32'(state), 0);
    check("rst_in_enable", 32'(in_enable), 1);

    // Full frame: 12 beats, tlast on the last, then 12 emits.
    for (int i = 1; i <= 12; i++) begin
      drive(1, 1, i == 12, 0, 0);
      tick();
    end
    check("full_col", 32'(col_index), 3);
    check("full_flush", 32'(state), 2);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1, 1);
      tick();
    end
    check("full_still_flush", 32'(state), 2);
    drain_seen = 0;
    done_seen = 0;
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (state == 2'd3) drain_seen++;
      if (obd) done_seen++;
    end
    check("full_drain_cycles", 32'(drain_seen), 2);
    check("full_done_pulses", 32'(done_seen), 1);
    check("full_err", 32'(tlast_error), 0);
    check("full_idle", 32'(state), 0);

    // Early tlast on beat 6.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, i == 6, 0, 0);
      tick();
    end
    check("early_err", 32'(tlast_error), 1);
    check("early_col", 32'(col_index), 2);
    check("early_flush", 32'(state), 2);
    wait_done("early_done", 40);

    // Width overflow without tlast.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      drive(1, 1, 0, 0, 0);
      tick();
    end
    check("ovf_err", 32'(tlast_error), 1);
    check("ovf_flush", 32'(state), 2);
    check("ovf_in_enable", 32'(in_enable), 0);
    wait_done("ovf_done", 40);

    // Output backpressure holds FLUSH.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, i == 4, 0, 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0);
      tick();
      check("bp_flush", 32'(state), 2);
      check("bp_no_done", 32'(obd), 0);
    end
    wait_done("bp_done", 40);

    // Reset during DRAIN.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, i == 4, 0, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check("rd_in_drain", 32'(state), 3);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("rd_state", 32'(state), 0);
    check("rd_in_enable", 32'(in_enable), 1);
    check("rd_flush", 32'(flush_req), 0);
    check("rd_done", 32'(obd), 0);
    check("rd_frame_done", 32'(frame_done), 0);
    check("rd_col", 32'(col_index), 0);
    tick();
    check("rd_no_late_done", 32'(obd), 0);

`ifdef COLUMN_SCHED_STATS_EN
    // Upstream stall counting in STREAM.
    do_reset();
    drive(1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
    check("stall_7", stall_cycles, 32'd7);
    do_reset();
`endif

    // Randomized frames.
    do_reset();
    for (int f = 0; f < 8; f++) begin
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        in_tvalid  = ($urandom_range(0, 3) != 0);
        in_tready  = ($urandom_range(0, 3) != 0);
        in_tlast   = ($urandom_range(0, 7) == 0);
        out_tready = ($urandom_range(0, 3) != 0);
        if (m_phase == 2 && m_emit / H < m_col) out_tvalid = ($urandom_range(0, 1) == 1);
        else if (m_phase == 3) out_tvalid = ($urandom_range(0, 1) == 1);
        else out_tvalid = 1'b0;
        tick();
        if (obd) seen = 1'b1;
      end
      check("rand_frame_done", 32'(seen), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/column_scheduler.md
COLUMN_SCHEDULER -- requirements
Module: column_scheduler

Interface
REQ-001 SHALL provide parameter BLOCK_SIZE, default 3: convolution window width in columns.
REQ-002 SHALL provide parameter INPUT_HEIGHT, default 480: pixels (beats) per column.
REQ-003 SHALL provide parameter IMAGE_WIDTH, default 640: maximum columns per frame.
REQ-004 SHALL provide parameter PIPE_LATENCY, default 4: drain cycles after the last output beat.
REQ-005 SHALL have port aclk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port areset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port in_tvalid, input, 1: upstream AXI-Stream valid, monitored.
REQ-008 SHALL have port in_tready, input, 1: upstream AXI-Stream ready, monitored.
REQ-009 SHALL have port in_tlast, input, 1: upstream end-of-frame marker.
REQ-010 SHALL have port out_tvalid, input, 1: downstream valid, monitored.
REQ-011 SHALL have port out_tready, input, 1: downstream ready, monitored.
REQ-012 SHALL have port in_enable, output, 1: gate ANDed into the buffer's tready.
REQ-013 SHALL have port flush_req, output, 1: requests zero-padding flush from the input buffer.
REQ-014 SHALL have port output_buffer_is_done, output, 1: one-cycle batch-complete pulse.
REQ-015 SHALL have port col_index, output, $clog2(IMAGE_WIDTH+1): columns accepted this frame.
REQ-016 SHALL have port state, output, 2: current FSM state encoding.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse, same cycle as output_buffer_is_done.
REQ-018 SHALL have port tlast_error, output, 1: sticky framing error flag.

Function
REQ-019 SHALL define accept = in_tvalid&&in_tready, and emit = out_tvalid&&out_tready.
REQ-020 SHALL implement states IDLE=0, STREAM=1, FLUSH=2, DRAIN=3, driven on state.
REQ-021 SHALL assert in_enable in IDLE and STREAM only; flush_req only in FLUSH.
REQ-022 SHALL move IDLE->STREAM on the first accept; that beat counts as row 0.
REQ-023 SHALL count accepted rows 0..INPUT_HEIGHT-1; on accept at row INPUT_HEIGHT-1, wrap to 0 and increment col_index.
REQ-024 SHALL move STREAM->FLUSH on accept with in_tlast=1 (an accept with in_tlast=1 from IDLE SHALL go directly to FLUSH).
REQ-025 SHALL set tlast_error if tlast is accepted at row != INPUT_HEIGHT-1; col_index still increments (partial column counted).
REQ-026 SHALL, when col_index reaches IMAGE_WIDTH without tlast, set tlast_error and enter FLUSH.
REQ-027 SHALL count emitted beats modulo INPUT_HEIGHT into an output column counter, counting emits in all states.
REQ-028 SHALL move FLUSH->DRAIN in the cycle the output column counter equals col_index.
REQ-029 SHALL hold DRAIN for PIPE_LATENCY cycles, then pulse output_buffer_is_done and frame_done and return to IDLE.
REQ-030 SHALL, on the IDLE return, clear col_index, row and output counters; tlast_error SHALL persist.
REQ-031 SHALL ignore accepts occurring in FLUSH/DRAIN (protocol violation; no counter change).
REQ-032 SHALL register all outputs; there is no combinational path from any input to any output.

Reset
REQ-033 SHALL, while areset=1 at the clock edge, force state=IDLE, in_enable=1, flush_req=0, output_buffer_is_done=0, frame_done=0, col_index=0, tlast_error=0, and all counters to 0.
REQ-034 SHALL give reset priority over every event, including mid-FLUSH or mid-DRAIN.

Configuration
REQ-035 SHALL, with COLUMN_SCHED_STATS_EN defined, add output stall_cycles (32 bits), counting STREAM cycles with in_tvalid&&!in_tready, saturating at all-ones, cleared by reset and on IDLE entry.
REQ-036 SHALL, without COLUMN_SCHED_STATS_EN, omit the stall_cycles port and its logic entirely.

Verification (INPUT_HEIGHT=4, IMAGE_WIDTH=3, BLOCK_SIZE=3, PIPE_LATENCY=2)
REQ-037 SHALL verify: 12 back-to-back accepts, tlast on beat 12, then 12 emits -> col_index=3, FLUSH, DRAIN for 2 cycles, single done pulse, tlast_error=0.
REQ-038 SHALL verify: tlast on accepted beat 6 -> tlast_error=1, col_index=2, FLUSH entered the next cycle.
REQ-039 SHALL verify: 12 accepts without tlast -> tlast_error=1, FLUSH entered, in_enable=0.
REQ-040 SHALL verify: out_tready held low 5 cycles during FLUSH -> state stays FLUSH; no done pulse until emits complete.
REQ-041 SHALL verify: areset=1 during DRAIN -> next cycle state=IDLE, all outputs at reset values, no done pulse.
REQ-042 SHALL verify (stats build): in_tvalid=1, in_tready=0 for 7 STREAM cycles -> stall_cycles=7.
